// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: register counts and the physical tag type.
// Used by rename, ROB and the physical-register free list.
package ooo_pkg;

    localparam int NUM_PREGS = 128;
    localparam int NUM_AREGS = 32;
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W    = $clog2(NUM_PREGS);

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit <-> free-list handshake bundle.
// Optional macro FREELIST_FLUSH_EN adds the flush and commit_alloc signals.
interface preg_free_list_if;
    import ooo_pkg::*;

    logic  alloc_req;
    preg_t alloc_preg;
    logic  alloc_ready;
    logic  free_valid;
    preg_t free_preg;
    preg_t free_count;
    logic  err_overflow;
`ifdef FREELIST_FLUSH_EN
    logic  flush;
    logic  commit_alloc;

    modport master (
        output alloc_req, free_valid, free_preg, flush, commit_alloc,
        input  alloc_preg, alloc_ready, free_count, err_overflow
    );

    modport slave (
        input  alloc_req, free_valid, free_preg, flush, commit_alloc,
        output alloc_preg, alloc_ready, free_count, err_overflow
    );
`else
    modport master (
        output alloc_req, free_valid, free_preg,
        input  alloc_preg, alloc_ready, free_count, err_overflow
    );

    modport slave (
        input  alloc_req, free_valid, free_preg,
        output alloc_preg, alloc_ready, free_count, err_overflow
    );
`endif

endinterface

// File: rtl/preg_free_list_wrap_ptr.sv
// Modulo-DEPTH incrementing pointer with enable, parallel load and
// synchronous reset. DEPTH need not be a power of two, so the wrap from
// DEPTH-1 back to 0 is explicit.
module wrap_ptr #(
    parameter int DEPTH = 96,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    // Pointer register: load wins over increment; increment wraps at DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_en) begin
            r_ptr <= (r_ptr == W'(DEPTH - 1)) ? '0 : r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list for the rename stage.
// Rename peeks the head and pops on a real destination write; commit pushes
// superseded registers at the tail. Storage is a circular array that resets
// to P(NUM_AREGS)..P(NUM_PREGS-1).
// Optional macro FREELIST_FLUSH_EN adds a committed-head checkpoint so a
// flush can rewind every speculative allocation in one cycle.
module preg_free_list
    import ooo_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    preg_free_list_if.slave fl_bus
);

    localparam int    DEPTH     = FL_DEPTH;
    localparam int    PTR_W     = $clog2(DEPTH);
    localparam preg_t DEPTH_CNT = preg_t'(DEPTH);
    localparam preg_t ONE_CNT   = preg_t'(1);

    preg_t            r_array [DEPTH];
    preg_t            r_count;
    logic             r_err_overflow;

    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic             w_empty;
    logic             w_full;
    logic             w_free_nz;
    logic             w_pop;
    logic             w_push;
    logic             w_overflow;
    logic             w_head_load;
    logic [PTR_W-1:0] w_head_load_val;
    preg_t            w_count_step;
    preg_t            w_count_next;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_CNT);
    assign w_free_nz  = fl_bus.free_valid && (fl_bus.free_preg != '0);
    assign w_push     = w_free_nz && !w_full;
    assign w_overflow = w_free_nz && w_full;

`ifdef FREELIST_FLUSH_EN
    logic [PTR_W-1:0] w_commit_head;
    logic [PTR_W-1:0] w_commit_head_next;
    preg_t            r_spec_count;
    preg_t            w_spec_after_commit;

    assign w_pop = fl_bus.alloc_req && !w_empty && !fl_bus.flush;

    assign w_commit_head_next = !fl_bus.commit_alloc ? w_commit_head :
                                (w_commit_head == PTR_W'(DEPTH - 1)) ? '0 :
                                w_commit_head + PTR_W'(1);

    assign w_spec_after_commit = fl_bus.commit_alloc ? (r_spec_count - ONE_CNT)
                                                     : r_spec_count;

    assign w_head_load     = fl_bus.flush;
    assign w_head_load_val = w_commit_head_next;

    wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_commit_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (fl_bus.commit_alloc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_commit_head)
    );

    // Speculative allocation count: pops add, retirements subtract, flush clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec_count <= '0;
        end else if (fl_bus.flush) begin
            r_spec_count <= '0;
        end else if (w_pop) begin
            r_spec_count <= w_spec_after_commit + ONE_CNT;
        end else begin
            r_spec_count <= w_spec_after_commit;
        end
    end
`else
    assign w_pop           = fl_bus.alloc_req && !w_empty;
    assign w_head_load     = 1'b0;
    assign w_head_load_val = '0;
`endif

    wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_head_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_pop),
        .i_load     (w_head_load),
        .i_load_val (w_head_load_val),
        .o_ptr      (w_head)
    );

    wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_tail_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_push),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_tail)
    );

    // Next occupancy: push/pop net change, plus rewound entries on a flush.
    always_comb begin
        w_count_step = r_count;
        if (w_push && !w_pop) begin
            w_count_step = r_count + ONE_CNT;
        end else if (w_pop && !w_push) begin
            w_count_step = r_count - ONE_CNT;
        end
        w_count_next = w_count_step;
`ifdef FREELIST_FLUSH_EN
        if (fl_bus.flush) begin
            w_count_next = w_count_step + w_spec_after_commit;
        end
`endif
    end

    // Occupancy register; reset means every non-architectural register is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= DEPTH_CNT;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (w_overflow) begin
            r_err_overflow <= 1'b1;
        end
    end

    // Entry storage: reset to the initial free pool, write returned tags at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_array[i] <= preg_t'(NUM_AREGS + i);
            end
        end else if (w_push) begin
            r_array[w_tail] <= fl_bus.free_preg;
        end
    end

    assign fl_bus.alloc_preg   = r_array[w_head];
    assign fl_bus.alloc_ready  = !w_empty;
    assign fl_bus.free_count   = r_count;
    assign fl_bus.err_overflow = r_err_overflow;

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list. The reference model is a plain
// queue of free tags (plus a queue of speculative allocations when
// FREELIST_FLUSH_EN is defined).
module tb_preg_free_list;
    import ooo_pkg::*;

    localparam int DEPTH = NUM_PREGS - NUM_AREGS;

    logic clk;
    logic rst;

    preg_free_list_if fl_bus ();

    preg_free_list dut (
        .clk    (clk),
        .rst    (rst),
        .fl_bus (fl_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int fq[$];
    int specq[$];
    bit mErr;

    task automatic resetModel();
        fq.delete();
        specq.delete();
        for (int i = 0; i < DEPTH; i++) fq.push_back(NUM_AREGS + i);
        mErr = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic  expReady;
        preg_t expCount;
        preg_t expPreg;
        logic  expErr;
        expReady = (fq.size() != 0);
        expCount = preg_t'(fq.size());
        expErr   = mErr;
        checks++;
        assert (fl_bus.alloc_ready === expReady) else begin
            errors++;
            $error("[TB] FAIL %s alloc_ready got %b want %b", tag, fl_bus.alloc_ready, expReady);
        end
        checks++;
        assert (fl_bus.free_count === expCount) else begin
            errors++;
            $error("[TB] FAIL %s free_count got %0d want %0d", tag, fl_bus.free_count, expCount);
        end
        checks++;
        assert (fl_bus.err_overflow === expErr) else begin
            errors++;
            $error("[TB] FAIL %s err_overflow got %b want %b", tag, fl_bus.err_overflow, expErr);
        end
        if (fq.size() != 0) begin
            expPreg = preg_t'(fq[0]);
            checks++;
            assert (fl_bus.alloc_preg === expPreg) else begin
                errors++;
                $error("[TB] FAIL %s alloc_preg got %0d want %0d", tag, fl_bus.alloc_preg, expPreg);
            end
        end
    endtask

    // One clock: update the model from the rules, drive, clock, then compare.
    task automatic applyStimulus(input bit areq, input bit fv, input int fp,
                                 input bit fl, input bit ca, input string tag);
        int  sz;
        bit  doPop;
        bit  doPush;
        bit  doOvf;
        int  p;
        sz     = fq.size();
        doPop  = areq && (sz > 0) && !fl;
        doPush = fv && (fp != 0) && (sz != DEPTH);
        doOvf  = fv && (fp != 0) && (sz == DEPTH);
        if (doPop) begin
            p = fq.pop_front();
            specq.push_back(p);
        end
        if (ca && specq.size() > 0) void'(specq.pop_front());
        if (doPush) fq.push_back(fp);
        if (doOvf) mErr = 1'b1;
        if (fl) begin
            fq = {specq, fq};
            specq.delete();
        end
        fl_bus.alloc_req  = areq;
        fl_bus.free_valid = fv;
        fl_bus.free_preg  = preg_t'(fp);
`ifdef FREELIST_FLUSH_EN
        fl_bus.flush        = fl;
        fl_bus.commit_alloc = ca;
`endif
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic resetDut(input bit fv, input int fp);
        rst               = 1'b1;
        fl_bus.alloc_req  = 1'b1;
        fl_bus.free_valid = fv;
        fl_bus.free_preg  = preg_t'(fp);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        checkOutput("reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        fl_bus.alloc_req  = 1'b0;
        fl_bus.free_valid = 1'b0;
        fl_bus.free_preg  = '0;
`ifdef FREELIST_FLUSH_EN
        fl_bus.flush        = 1'b0;
        fl_bus.commit_alloc = 1'b0;
`endif
        resetModel();

        // Reset state and first allocations
        resetDut(1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, "alloc3");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, "peekhold");

        // Drain to empty, then an alloc while empty is ignored
        for (int i = 0; i < DEPTH - 3; i++) applyStimulus(1, 0, 0, 0, 0, "drain");
        applyStimulus(1, 0, 0, 0, 0, "alloc_empty");
        // Push into empty with alloc_req held: no bypass, then visible
        applyStimulus(1, 1, 40, 0, 0, "free40_empty");
        applyStimulus(0, 0, 0, 0, 0, "after_free40");

        // Wrap-around: head at last slot, pop and push together
        resetDut(1'b0, 0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1, 0, 0, 0, 0, "to_last");
        applyStimulus(1, 1, 50, 0, 0, "wrap_poppush");
        applyStimulus(0, 0, 0, 0, 0, "wrap_hold");

        // x0 drop, fill to full, overflow and stickiness
        resetDut(1'b0, 0);
        applyStimulus(1, 0, 0, 0, 0, "pop_one");
        applyStimulus(0, 1, 0, 0, 0, "free_x0");
        applyStimulus(0, 1, 32, 0, 0, "refill");
        applyStimulus(0, 1, 99, 0, 0, "overflow");
        applyStimulus(1, 0, 0, 0, 0, "sticky");
        applyStimulus(1, 1, 0, 0, 0, "x0_notfull");

        // Randomized phases alternating drain-heavy and fill-heavy traffic
        resetDut(1'b0, 0);
        for (int blk = 0; blk < 8; blk++) begin
            int pa;
            int pf;
            pa = (blk % 2 == 0) ? 85 : 25;
            pf = (blk % 2 == 0) ? 20 : 90;
            for (int i = 0; i < 250; i++) begin
                bit a;
                bit f;
                int v;
                a = ($urandom_range(0, 99) < pa);
                f = ($urandom_range(0, 99) < pf);
                v = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, NUM_PREGS - 1));
                applyStimulus(a, f, v, 0, 0, "random");
            end
            specq.delete();
        end

        // Reset mid-operation with a free in flight discards it
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 70 + i, 0, 0, "pre_rst");
        resetDut(1'b1, 77);

`ifdef FREELIST_FLUSH_EN
        // Rewind speculative allocations after two retirements
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, "spec_alloc");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 1, "commit");
        applyStimulus(0, 0, 0, 1, 0, "flush");
        // Flush with alloc_req (ignored), a free and a same-cycle retirement
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, "spec_alloc2");
        applyStimulus(0, 1, 60, 0, 0, "free60");
        applyStimulus(1, 1, 77, 1, 1, "flush_combo");
        applyStimulus(0, 0, 0, 0, 0, "post_flush");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
